// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, blank pattern and the
// active-low hex glyph table used by every display block.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Entry n is the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
  localparam logic [15:0][6:0] HEX7_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex7(input logic [3:0] digit);
    return HEX7_LUT[digit];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data and drive bundle between a value source and seg7_scan_driver.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic                    frame_start;

  modport master (
    output value, blank, dp, lz_en,
    input  an, seg, dp_n, frame_start
  );

  modport slave (
    input  value, blank, dp, lz_en,
    output an, seg, dp_n, frame_start
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex digit to active-low {g,f,e,d,c,b,a} segment decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] code;

  always_comb begin
    code = hex7(digit);
    seg  = {code[SEG_G], code[SEG_F], code[SEG_E], code[SEG_D],
            code[SEG_C], code[SEG_B], code[SEG_A]};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver advanced by scan_clk rising
// edges, with per-frame latching, blanking, decimal points and zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                scan_clk,
  seg7_scan_driver_if.slave   bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                    scan_q;
  logic                    rise;
  logic                    load;
  logic                    load_pend;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] value_f;
  logic [NUM_DIGITS-1:0]   blank_f;
  logic [NUM_DIGITS-1:0]   dp_f;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  logic [3:0]              cur_digit;
  logic [6:0]              cur_seg;

  assign rise      = scan_clk & ~scan_q;
  assign load      = load_pend | (rise & (idx == LAST_IDX));
  assign cur_digit = value_f[{idx, 2'b00} +: 4];

  // Walk from the most significant digit down; a digit is blanked only while
  // every digit above it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run & (value_f[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if (i != NUM_DIGITS - 1)
        supp[NUM_DIGITS-1-i] = bus.lz_en & zero_run;
    end
  end

  seg7_hex_decoder u_dec (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      scan_q    <= 1'b0;
      idx       <= '0;
      load_pend <= 1'b1;
      value_f   <= '0;
      blank_f   <= '0;
      dp_f      <= '0;
    end else begin
      scan_q <= scan_clk;
      if (rise)
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      if (load) begin
        value_f   <= bus.value;
        blank_f   <= bus.blank;
        dp_f      <= bus.dp;
        load_pend <= 1'b0;
      end
    end
  end

  // an and seg come from the same idx on the same edge, so no ghosting cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      bus.an          <= '1;
      bus.seg         <= SEG_OFF;
      bus.dp_n        <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.an          <= ~(NUM_DIGITS'(1) << idx);
      bus.seg         <= (blank_f[idx] | supp[idx]) ? SEG_OFF : cur_seg;
      bus.dp_n        <= ~dp_f[idx];
      bus.frame_start <= load;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed-vector self-checking bench for seg7_scan_driver (4 digits).
module tb_seg7_scan_driver;

  logic clk_in;
  logic rst;
  logic scan_clk;
  int   n_cmp;
  int   n_err;
  int   fs;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .IDX_W      (2)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .scan_clk (scan_clk),
    .bus      (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One scan_clk period of 4 system cycles; counts frame_start pulses seen.
  task automatic pulse(output int fs_cnt);
    fs_cnt = 0;
    scan_clk = 1'b1;
    repeat (2) begin
      @(negedge clk_in);
      fs_cnt += int'(bus.frame_start);
    end
    scan_clk = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      fs_cnt += int'(bus.frame_start);
    end
  endtask

  task automatic show(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    check({tag, ".an"}, 32'(bus.an), 32'(an_exp));
    check({tag, ".seg"}, 32'(bus.seg), 32'(seg_exp));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    scan_clk = 1'b0;
    bus.value = 16'h1234;
    bus.blank = 4'h0;
    bus.dp = 4'h0;
    bus.lz_en = 1'b0;

    tick(5);
    show("rst", 4'hF, 7'h7F);
    check("rst.dp_n", 32'(bus.dp_n), 32'd1);
    check("rst.fs", 32'(bus.frame_start), 32'd0);
    rst = 1'b0;
    tick(1);
    check("rel.fs", 32'(bus.frame_start), 32'd1);
    check("rel.an", 32'(bus.an), 32'hE);
    tick(1);
    show("rel2", 4'hE, 7'h19);
    check("rel2.fs", 32'(bus.frame_start), 32'd0);

    pulse(fs); show("scan1", 4'hD, 7'h30); check("scan1.fs", 32'(fs), 32'd0);
    pulse(fs); show("scan2", 4'hB, 7'h24); check("scan2.fs", 32'(fs), 32'd0);
    pulse(fs); show("scan3", 4'h7, 7'h79); check("scan3.fs", 32'(fs), 32'd0);
    pulse(fs); show("scan4", 4'hE, 7'h19); check("scan4.fs", 32'(fs), 32'd1);

    pulse(fs);
    pulse(fs); show("mid.d2", 4'hB, 7'h24);
    bus.value = 16'hABCD;
    tick(3);   show("mid.d2hold", 4'hB, 7'h24);
    pulse(fs); show("mid.d3old", 4'h7, 7'h79);
    pulse(fs); show("new.d0", 4'hE, 7'h21); check("new.fs", 32'(fs), 32'd1);
    pulse(fs); show("new.d1", 4'hD, 7'h46);
    pulse(fs); show("new.d2", 4'hB, 7'h03);
    pulse(fs); show("new.d3", 4'h7, 7'h08);

    bus.value = 16'h0050;
    bus.lz_en = 1'b1;
    pulse(fs); show("lz50.d0", 4'hE, 7'h40);
    pulse(fs); show("lz50.d1", 4'hD, 7'h12);
    pulse(fs); show("lz50.d2", 4'hB, 7'h7F);
    pulse(fs); show("lz50.d3", 4'h7, 7'h7F);
    bus.value = 16'h0000;
    pulse(fs); show("lz0.d0", 4'hE, 7'h40);
    pulse(fs); show("lz0.d1", 4'hD, 7'h7F);
    pulse(fs); show("lz0.d2", 4'hB, 7'h7F);
    pulse(fs); show("lz0.d3", 4'h7, 7'h7F);
    bus.lz_en = 1'b0;
    tick(1);   show("lz.live", 4'h7, 7'h40);

    bus.value = 16'h8888;
    bus.blank = 4'b0100;
    bus.dp = 4'b0100;
    pulse(fs); show("bl.d0", 4'hE, 7'h00); check("bl.d0.dp", 32'(bus.dp_n), 32'd1);
    pulse(fs); show("bl.d1", 4'hD, 7'h00); check("bl.d1.dp", 32'(bus.dp_n), 32'd1);
    pulse(fs); show("bl.d2", 4'hB, 7'h7F); check("bl.d2.dp", 32'(bus.dp_n), 32'd0);
    pulse(fs); show("bl.d3", 4'h7, 7'h00); check("bl.d3.dp", 32'(bus.dp_n), 32'd1);

    bus.value = 16'h1234;
    bus.blank = 4'h0;
    bus.dp = 4'h0;
    pulse(fs); show("hold.d0", 4'hE, 7'h19);
    scan_clk = 1'b1;
    tick(20);  show("hold.hi", 4'hD, 7'h30);
    scan_clk = 1'b0;
    tick(10);  show("hold.lo", 4'hD, 7'h30);
    pulse(fs); show("hold.d2", 4'hB, 7'h24);
    pulse(fs); show("hold.d3", 4'h7, 7'h79);

    rst = 1'b1;
    tick(1);   show("midrst", 4'hF, 7'h7F);
    check("midrst.dp_n", 32'(bus.dp_n), 32'd1);
    rst = 1'b0;
    tick(1);
    check("rerel.fs", 32'(bus.frame_start), 32'd1);
    check("rerel.an", 32'(bus.an), 32'hE);
    tick(1);   show("rerel.d0", 4'hE, 7'h19);
    pulse(fs); show("rerel.d1", 4'hD, 7'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
